imem_program_loader: RTL and testbench
======================================

Name: imem_program_loader

Overview:
- Upstream feeder for the single-cycle CPU's instruction-memory initialize port.
- Receives a length-prefixed byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words.
- Writes each word to consecutive instruction addresses through the initialize / instruction_initialize_data / instruction_initialize_address ports.
- Holds the CPU in reset for the whole load, then releases it to run from BASE_ADDR.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of the first word written.
- DEPTH, 64: instruction memory capacity in words; a header count above this is an error.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- load_start  input  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR; ignored in all other states.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid && byte_ready.
- initialize  output  1  instruction-memory write strobe; drives cpu.initialize.
- instruction_initialize_data  output  32  word to write.
- instruction_initialize_address  output  32  byte address of the word.
- cpu_rst_out  output  1  active-high; drives cpu.rst; 1 holds the CPU/PC in reset.
- done  output  1  load completed successfully; level output.
- error  output  1  header count exceeded DEPTH; level output.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - initialize=0, instruction_initialize_data=0, instruction_initialize_address=BASE_ADDR.
  - cpu_rst_out=1, done=0, error=0, byte_ready=0.
  - Word count, byte counter and shift register cleared.
  - Reset mid-load abandons the load; words already written stay in memory.
- States: IDLE, LEN_HI, LEN_LO, WORD, WRITE, DONE, ERROR.
- IDLE:
  - byte_ready=0, cpu_rst_out=1.
  - On load_start: go to LEN_HI; clear done/error; address=BASE_ADDR.
- LEN_HI / LEN_LO:
  - byte_ready=1.
  - Each accepted byte loads count[15:8], then count[7:0].
  - Leaving LEN_LO:
    - count==0 -> DONE (no writes).
    - count>DEPTH -> ERROR.
    - otherwise -> WORD with byte_cnt=0.
- WORD:
  - byte_ready=1.
  - Each accepted byte shifts in MSB-first: word={word[23:0],byte_in}; byte_cnt increments.
  - Fourth accepted byte -> WRITE next cycle.
- WRITE (exactly one cycle):
  - initialize=1, byte_ready=0.
  - instruction_initialize_data and instruction_initialize_address are stable for the whole cycle.
  - Next cycle:
    - address += 4, remaining count -= 1, initialize=0.
    - remaining==0 -> DONE; else -> WORD with byte_cnt=0.
- Latency: initialize rises on the first clock edge after the 4th byte of a word is accepted.
- Address arithmetic: 32-bit, no wrap checking beyond the DEPTH limit. The last write address is BASE_ADDR+4*(N-1).
- DONE:
  - done=1, cpu_rst_out=0, byte_ready=0.
  - load_start -> LEN_HI, cpu_rst_out=1, done=0 in the same edge.
- ERROR:
  - error=1, cpu_rst_out=1, byte_ready=0, no writes.
  - Only load_start or rst exits.
- load_start while in LEN_HI, LEN_LO, WORD or WRITE is ignored.
- byte_valid while byte_ready=0 is not consumed; the upstream holds the byte.
- initialize is never asserted outside WRITE.
- cpu_rst_out is 1 in every state except DONE.

Test Plan:
- Basic load:
  - Stimulus: load_start; bytes 00 02 20 08 00 05 8C 09 00 04.
  - Response: two initialize pulses:
    - addr 0x0, data 0x2008_0005.
    - addr 0x4, data 0x8C09_0004.
  - Then done=1, cpu_rst_out=0, byte_ready=0.
- Zero length: header 00 00 -> DONE, no initialize pulse, done=1 two accepted bytes after start.
- Overflow: DEPTH=64, header 00 41 -> error=1, cpu_rst_out=1, no initialize; later load_start with a valid 1-word stream -> done=1, error=0.
- Backpressure / gaps:
  - Stimulus: byte_valid toggles every other cycle, and byte_valid held high during WRITE.
  - Response: byte_ready=0 in WRITE, no byte lost or duplicated, data matches.
- Async reset: rst=0 between the 2nd and 3rd byte of word 1 -> all outputs at reset values immediately, state IDLE. A fresh load then writes from BASE_ADDR.
- Reload from DONE: second load_start with a 1-word stream 0xFFFF_0000 -> cpu_rst_out reasserts on the start edge, one write at addr 0x0, then done=1.

Source files
------------

// File: rtl/imem_program_loader_if.sv
// Byte-stream input and instruction-memory initialize bus of the program loader.
// The slave modport is the loader side. The master modport is the feeder/observer side.
interface imem_program_loader_if;
  logic        load_start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;
  logic        cpu_rst_out;
  logic        done;
  logic        error;

  modport slave (
    input  load_start,
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output initialize,
    output instruction_initialize_data,
    output instruction_initialize_address,
    output cpu_rst_out,
    output done,
    output error
  );

  modport master (
    output load_start,
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  initialize,
    input  instruction_initialize_data,
    input  instruction_initialize_address,
    input  cpu_rst_out,
    input  done,
    input  error
  );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// It takes a 16-bit big-endian word count and then that many big-endian 32-bit words.
// Each word is written to consecutive instruction addresses starting at BASE_ADDR.
// The CPU is held in reset except after a successful load.
module imem_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_program_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    WORD,
    WRITE,
    DONE,
    ERROR
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;

  logic        byte_ready_int;
  logic        accept;
  logic [15:0] len_full;

  assign accept   = bus.byte_valid && byte_ready_int;
  assign len_full = {count_q[15:8], bus.byte_in};

  // State and datapath registers; an asynchronous reset abandons any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= 16'd0;
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      addr_q     <= BASE_ADDR;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
    end
  end

  // Next-state and datapath update: header capture, word assembly, and post-write advance.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (bus.load_start) begin
          state_d = LEN_HI;
          addr_d  = BASE_ADDR;
        end
      end
      LEN_HI: begin
        if (accept) begin
          count_d = {bus.byte_in, count_q[7:0]};
          state_d = LEN_LO;
        end
      end
      LEN_LO: begin
        if (accept) begin
          count_d    = len_full;
          byte_cnt_d = 2'd0;
          if (len_full == 16'd0) begin
            state_d = DONE;
          end else if (len_full > DEPTH_W) begin
            state_d = ERROR;
          end else begin
            state_d = WORD;
          end
        end
      end
      WORD: begin
        if (accept) begin
          word_d     = {word_q[23:0], bus.byte_in};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d     = addr_q + 32'd4;
        count_d    = count_q - 16'd1;
        byte_cnt_d = 2'd0;
        state_d    = (count_q == 16'd1) ? DONE : WORD;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state; the CPU runs only in DONE.
  always_comb begin
    byte_ready_int  = 1'b0;
    bus.initialize  = 1'b0;
    bus.cpu_rst_out = 1'b1;
    bus.done        = 1'b0;
    bus.error       = 1'b0;
    case (state_q)
      LEN_HI, LEN_LO, WORD: byte_ready_int = 1'b1;
      WRITE:                bus.initialize = 1'b1;
      DONE: begin
        bus.done        = 1'b1;
        bus.cpu_rst_out = 1'b0;
      end
      ERROR:                bus.error      = 1'b1;
      default:              byte_ready_int = 1'b0;
    endcase
  end

  assign bus.byte_ready                     = byte_ready_int;
  assign bus.instruction_initialize_data    = word_q;
  assign bus.instruction_initialize_address = addr_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed scoreboard bench for imem_program_loader.
// Expected writes are queued as words are fed, and they are popped by the write monitor.
module tb_imem_program_loader;

  localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  imem_program_loader_if bus();

  imem_program_loader #(
    .BASE_ADDR(BASE_ADDR),
    .DEPTH(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int writeCount  = 0;
  logic [63:0] expQ[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Write monitor: every initialize pulse must match the oldest queued {address, data}.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (rst === 1'b1 && bus.initialize === 1'b1) begin
      writeCount++;
      checkOutput("write_expected", 32'(expQ.size() > 0), 32'd1);
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checkOutput("write_addr", bus.instruction_initialize_address, exp[63:32]);
        checkOutput("write_data", bus.instruction_initialize_data, exp[31:0]);
        checkOutput("write_ready_low", 32'(bus.byte_ready), 32'd0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulseStart();
    bus.load_start = 1'b1;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  // Offer one byte and hold it until the loader accepts it (bounded wait).
  task automatic applyStimulus(input logic [7:0] b);
    bit accepted = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.byte_ready === 1'b1) begin
        accepted = 1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
    if (!accepted) checkOutput("byte_accept_timeout", 32'(bus.byte_ready), 32'd1);
  endtask

  task automatic sendWord(input logic [31:0] data, input logic [31:0] addr, input bit gap);
    expQ.push_back({addr, data});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(data[31-8*i -: 8]);
      if (gap) idle(1);
    end
  endtask

  task automatic waitDone();
    for (int i = 0; i < 20; i++) begin
      if (bus.done === 1'b1) break;
      @(negedge clk);
    end
  endtask

  initial begin
    int wc;
    bus.load_start = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    rst            = 1'b0;
    idle(2);

    $display("[TB] reset state");
    checkOutput("rst_initialize", 32'(bus.initialize), 32'd0);
    checkOutput("rst_data", bus.instruction_initialize_data, 32'd0);
    checkOutput("rst_addr", bus.instruction_initialize_address, BASE_ADDR);
    checkOutput("rst_cpu_rst", 32'(bus.cpu_rst_out), 32'd1);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_error", 32'(bus.error), 32'd0);
    checkOutput("rst_ready", 32'(bus.byte_ready), 32'd0);
    rst = 1'b1;
    idle(2);
    checkOutput("idle_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("idle_cpu_rst", 32'(bus.cpu_rst_out), 32'd1);

    $display("[TB] basic two-word load");
    pulseStart();
    checkOutput("lenhi_ready", 32'(bus.byte_ready), 32'd1);
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    sendWord(32'h2008_0005, BASE_ADDR, 1'b0);
    sendWord(32'h8C09_0004, BASE_ADDR + 32'd4, 1'b0);
    waitDone();
    checkOutput("basic_done", 32'(bus.done), 32'd1);
    checkOutput("basic_cpu_rst", 32'(bus.cpu_rst_out), 32'd0);
    checkOutput("basic_ready", 32'(bus.byte_ready), 32'd0);
    checkOutput("basic_writes", 32'(writeCount), 32'd2);
    checkOutput("basic_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] zero length");
    pulseStart();
    checkOutput("zero_start_cpu_rst", 32'(bus.cpu_rst_out), 32'd1);
    checkOutput("zero_start_done", 32'(bus.done), 32'd0);
    wc = writeCount;
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    checkOutput("zero_done", 32'(bus.done), 32'd1);
    idle(3);
    checkOutput("zero_no_write", 32'(writeCount), 32'(wc));

    $display("[TB] overflow header");
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h41);
    checkOutput("ovf_error", 32'(bus.error), 32'd1);
    checkOutput("ovf_cpu_rst", 32'(bus.cpu_rst_out), 32'd1);
    checkOutput("ovf_done", 32'(bus.done), 32'd0);
    checkOutput("ovf_ready", 32'(bus.byte_ready), 32'd0);
    bus.byte_valid = 1'b1;
    idle(3);
    bus.byte_valid = 1'b0;
    checkOutput("ovf_no_write", 32'(writeCount), 32'(wc));
    checkOutput("ovf_error_held", 32'(bus.error), 32'd1);
    pulseStart();
    checkOutput("ovf_restart_error", 32'(bus.error), 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    sendWord(32'h1234_5678, BASE_ADDR, 1'b0);
    waitDone();
    checkOutput("ovf_recover_done", 32'(bus.done), 32'd1);
    checkOutput("ovf_recover_error", 32'(bus.error), 32'd0);

    $display("[TB] backpressure and gaps");
    wc = writeCount;
    pulseStart();
    applyStimulus(8'h00);
    idle(1);
    applyStimulus(8'h03);
    idle(1);
    sendWord(32'hA1B2_C3D4, BASE_ADDR, 1'b1);
    sendWord(32'h0102_0304, BASE_ADDR + 32'd4, 1'b0);
    sendWord(32'hF0E1_D2C3, BASE_ADDR + 32'd8, 1'b0);
    waitDone();
    checkOutput("bp_done", 32'(bus.done), 32'd1);
    checkOutput("bp_writes", 32'(writeCount - wc), 32'd3);
    checkOutput("bp_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] async reset mid-word");
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_initialize", 32'(bus.initialize), 32'd0);
    checkOutput("arst_data", bus.instruction_initialize_data, 32'd0);
    checkOutput("arst_addr", bus.instruction_initialize_address, BASE_ADDR);
    checkOutput("arst_cpu_rst", 32'(bus.cpu_rst_out), 32'd1);
    checkOutput("arst_done", 32'(bus.done), 32'd0);
    checkOutput("arst_error", 32'(bus.error), 32'd0);
    checkOutput("arst_ready", 32'(bus.byte_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle(1);
    checkOutput("arst_idle_ready", 32'(bus.byte_ready), 32'd0);
    pulseStart();
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    sendWord(32'hDEAD_BEEF, BASE_ADDR, 1'b0);
    waitDone();
    checkOutput("arst_reload_done", 32'(bus.done), 32'd1);

    $display("[TB] reload from DONE");
    wc = writeCount;
    pulseStart();
    checkOutput("reload_cpu_rst", 32'(bus.cpu_rst_out), 32'd1);
    checkOutput("reload_done_clr", 32'(bus.done), 32'd0);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    sendWord(32'hFFFF_0000, BASE_ADDR, 1'b0);
    waitDone();
    checkOutput("reload_done", 32'(bus.done), 32'd1);
    checkOutput("reload_cpu_run", 32'(bus.cpu_rst_out), 32'd0);
    checkOutput("reload_writes", 32'(writeCount - wc), 32'd1);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
